// File: rtl/cmdspi_regs_pkg.sv
// Shared constants for the cmdspi register bank: address map, STATUS bit
// positions and the default ID word.
package cmdspi_regs_pkg;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'h1CE4_0001;

  localparam logic [6:0] ADDR_ID         = 7'h00;
  localparam logic [6:0] ADDR_SCRATCH    = 7'h01;
  localparam logic [6:0] ADDR_CTRL       = 7'h02;
  localparam logic [6:0] ADDR_STATUS     = 7'h03;
  localparam logic [6:0] ADDR_FIFO_DATA  = 7'h04;
  localparam logic [6:0] ADDR_FIFO_POP   = 7'h05;
  localparam logic [6:0] ADDR_SAMPLE_CNT = 7'h06;
  localparam logic [6:0] ADDR_PARAM0     = 7'h10;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_LEVEL_LSB = 16;

endpackage

// File: rtl/cmdspi_regs_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head. A pop on a full FIFO
// frees the slot that a same-cycle push then fills.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // Storage is not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmdspi_regs.sv
// Register bank behind the cmdspi slave: control/parameter registers for the
// DSP core plus a host-drained sample FIFO with sticky overflow and irq.
module cmdspi_regs
  import cmdspi_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE   = DEFAULT_ID_VALUE,
  parameter int          FIFO_DEPTH = 16,
  parameter int          NPARAM     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [6:0]             addr,
  input  logic [31:0]            wdat,
  output logic [31:0]            rdat,
  output logic [31:0]            ctrl,
  output logic [32*NPARAM-1:0]   param,
  input  logic                   s_valid,
  input  logic [31:0]            s_data,
  output logic                   irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]              scratch;
  logic [31:0]              sample_cnt;
  logic [NPARAM-1:0][31:0]  param_q;
  logic                     ovf;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [LW-1:0]            fifo_level;
  logic [31:0]              fifo_head;
  logic                     pop_req;
  logic                     push_ok;
  logic                     drop;
  logic                     param_hit;
  logic [31:0]              status;
  logic [31:0]              rd_nxt;
  logic [7:0]               irq_thr;
  logic [8:0]               level9;
  logic                     irq_nxt;

  assign pop_req   = we && (addr == ADDR_FIFO_POP);
  // Mirrors the FIFO's own accept rule so the counter and overflow agree with it.
  assign push_ok   = s_valid && (!fifo_full || (pop_req && !fifo_empty));
  assign drop      = s_valid && !push_ok;
  assign param_hit = (addr[6:4] == ADDR_PARAM0[6:4]) && (int'(addr[3:0]) < NPARAM);
  assign param     = param_q;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .pop   (pop_req),
    .din   (s_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status = '0;
    status[STATUS_EMPTY_BIT]          = fifo_empty;
    status[STATUS_FULL_BIT]           = fifo_full;
    status[STATUS_OVF_BIT]            = ovf;
    status[STATUS_LEVEL_LSB +: LW]    = fifo_level;
  end

  always_comb begin
    rd_nxt = '0;
    case (addr)
      ADDR_ID:         rd_nxt = ID_VALUE;
      ADDR_SCRATCH:    rd_nxt = scratch;
      ADDR_CTRL:       rd_nxt = ctrl;
      ADDR_STATUS:     rd_nxt = status;
      ADDR_FIFO_DATA:  rd_nxt = fifo_empty ? '0 : fifo_head;
      ADDR_SAMPLE_CNT: rd_nxt = sample_cnt;
      default: begin
        for (int k = 0; k < NPARAM; k++) begin
          if (param_hit && (addr[3:0] == 4'(k))) rd_nxt = param_q[k];
        end
      end
    endcase
  end

  assign irq_thr = ctrl[31:24];
  assign level9  = 9'(fifo_level);
  assign irq_nxt = ((irq_thr != 8'd0) && (level9 >= {1'b0, irq_thr})) || ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdat       <= '0;
      irq        <= 1'b0;
      scratch    <= '0;
      ctrl       <= '0;
      param_q    <= '0;
      ovf        <= 1'b0;
      sample_cnt <= '0;
    end else begin
      rdat <= rd_nxt;
      irq  <= irq_nxt;
      if (we && (addr == ADDR_SCRATCH)) scratch <= wdat;
      if (we && (addr == ADDR_CTRL))    ctrl    <= wdat;
      for (int k = 0; k < NPARAM; k++) begin
        if (we && param_hit && (addr[3:0] == 4'(k))) param_q[k] <= wdat;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)
        ovf <= 1'b1;
      else if (we && (addr == ADDR_STATUS) && wdat[STATUS_OVF_BIT])
        ovf <= 1'b0;
      if (we && (addr == ADDR_SAMPLE_CNT))
        sample_cnt <= push_ok ? 32'd1 : 32'd0;
      else if (push_ok)
        sample_cnt <= sample_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cmdspi_regs.sv
// Bench for cmdspi_regs: directed register-map/FIFO scenarios with literal
// expectations, then random traffic against a queue-based reference model.
module tb_cmdspi_regs;

  localparam int DEPTH = 16;
  localparam int NP    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we = 1'b0;
  logic [6:0]        addr = '0;
  logic [31:0]       wdat = '0;
  logic              s_valid = 1'b0;
  logic [31:0]       s_data = '0;
  logic [31:0]       rdat;
  logic [31:0]       ctrl;
  logic [32*NP-1:0]  param;
  logic              irq;

  always #5 clk = ~clk;

  cmdspi_regs #(.ID_VALUE(32'h1CE4_0001), .FIFO_DEPTH(DEPTH), .NPARAM(NP)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr    (addr),
    .wdat    (wdat),
    .rdat    (rdat),
    .ctrl    (ctrl),
    .param   (param),
    .s_valid (s_valid),
    .s_data  (s_data),
    .irq     (irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkp(input string name, input logic [32*NP-1:0] got, input logic [32*NP-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, registers as plain variables.
  logic [31:0] m_q[$];
  bit          m_ovf;
  logic [31:0] m_cnt, m_scratch, m_ctrl;
  logic [31:0] m_prm [NP];
  logic [31:0] m_rdat;
  bit          m_irq;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic [6:0] a);
    int lvl;
    int idx;
    lvl = m_q.size();
    idx = int'(a) - 16;
    case (int'(a))
      0: return 32'h1CE4_0001;
      1: return m_scratch;
      2: return m_ctrl;
      3: return {8'h00, 8'(lvl), 13'h0, m_ovf, (lvl == DEPTH), (lvl == 0)};
      4: return (lvl > 0) ? m_q[0] : 32'h0;
      6: return m_cnt;
      default: return (idx >= 0 && idx < NP) ? m_prm[idx] : 32'h0;
    endcase
  endfunction

  function automatic bit m_irq_now();
    int thr;
    thr = int'(m_ctrl[31:24]);
    return ((thr != 0) && (m_q.size() >= thr)) || m_ovf;
  endfunction

  function automatic logic [32*NP-1:0] m_param();
    logic [32*NP-1:0] p;
    for (int k = 0; k < NP; k++) p[32*k +: 32] = m_prm[k];
    return p;
  endfunction

  always @(posedge clk) begin
    bit pop, acc;
    if (rst) begin
      m_q.delete();
      m_ovf = 0; m_cnt = 0; m_scratch = 0; m_ctrl = 0;
      for (int k = 0; k < NP; k++) m_prm[k] = 0;
      m_rdat = 0; m_irq = 0; m_valid = 1;
    end else if (m_valid) begin
      m_rdat = m_read(addr);
      m_irq  = m_irq_now();
      pop = we && (addr == 7'h05) && (m_q.size() > 0);
      acc = s_valid && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(s_data);
      if (s_valid && !acc) m_ovf = 1;
      else if (we && addr == 7'h03 && wdat[2]) m_ovf = 0;
      if (we && addr == 7'h06) m_cnt = acc ? 32'd1 : 32'd0;
      else if (acc) m_cnt = m_cnt + 32'd1;
      if (we && addr == 7'h01) m_scratch = wdat;
      if (we && addr == 7'h02) m_ctrl = wdat;
      for (int k = 0; k < NP; k++)
        if (we && int'(addr) == 16 + k) m_prm[k] = wdat;
    end
    #1;
    if (m_valid) begin
      check32("model_rdat", rdat, m_rdat);
      check32("model_irq", {31'h0, irq}, {31'h0, m_irq});
      check32("model_ctrl", ctrl, m_ctrl);
      checkp("model_param", param, m_param());
    end
  end

  task automatic cyc(input bit r, input bit w, input logic [6:0] a, input logic [31:0] d,
                     input bit sv, input logic [31:0] sd);
    rst = r; we = w; addr = a; wdat = d; s_valid = sv; s_data = sd;
    @(negedge clk);
  endtask

  initial begin
    logic [6:0]  ra;
    logic [31:0] rd;
    @(negedge clk);
    cyc(1, 0, 7'h00, 0, 0, 0);
    check32("reset_rdat", rdat, 32'h0);
    check32("reset_ctrl", ctrl, 32'h0);
    check32("reset_irq", {31'h0, irq}, 32'h0);
    checkp("reset_param", param, '0);
    cyc(0, 0, 7'h00, 0, 0, 0);
    check32("id", rdat, 32'h1CE4_0001);
    cyc(0, 0, 7'h03, 0, 0, 0);
    check32("status_empty", rdat, 32'h0000_0001);

    cyc(0, 1, 7'h01, 32'h1234_5678, 0, 0);
    cyc(0, 1, 7'h13, 32'hA5A5_A5A5, 0, 0);
    check32("param3_out", param[127:96], 32'hA5A5_A5A5);
    cyc(0, 0, 7'h01, 0, 0, 0);
    check32("scratch_rd", rdat, 32'h1234_5678);
    cyc(0, 0, 7'h13, 0, 0, 0);
    check32("param3_rd", rdat, 32'hA5A5_A5A5);

    cyc(0, 0, 7'h04, 0, 1, 32'h11);
    cyc(0, 0, 7'h04, 0, 1, 32'h22);
    cyc(0, 0, 7'h04, 0, 1, 32'h33);
    cyc(0, 0, 7'h04, 0, 0, 0);
    check32("fifo_head", rdat, 32'h11);
    cyc(0, 0, 7'h03, 0, 0, 0);
    check32("level3", {24'h0, rdat[23:16]}, 32'd3);
    cyc(0, 1, 7'h05, 0, 0, 0);
    cyc(0, 0, 7'h04, 0, 0, 0);
    check32("head_after_pop", rdat, 32'h22);

    cyc(1, 0, 7'h00, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 7'h03, 0, 1, 32'h100 + 32'(i));
    cyc(0, 0, 7'h03, 0, 0, 0);
    check32("status_full_ovf", rdat, 32'h0010_0006);
    check32("irq_ovf", {31'h0, irq}, 32'd1);
    cyc(0, 0, 7'h06, 0, 0, 0);
    check32("cnt16", rdat, 32'd16);
    cyc(0, 1, 7'h03, 32'h4, 0, 0);
    cyc(0, 0, 7'h03, 0, 0, 0);
    check32("ovf_cleared", rdat, 32'h0010_0002);
    cyc(0, 1, 7'h05, 0, 1, 32'h99);
    cyc(0, 0, 7'h03, 0, 0, 0);
    check32("full_push_pop", rdat, 32'h0010_0002);
    cyc(0, 0, 7'h06, 0, 0, 0);
    check32("cnt17", rdat, 32'd17);

    cyc(1, 0, 7'h00, 0, 0, 0);
    cyc(0, 1, 7'h02, 32'h0400_0000, 0, 0);
    check32("ctrl_thr", ctrl, 32'h0400_0000);
    for (int i = 0; i < 4; i++) cyc(0, 0, 7'h00, 0, 1, 32'(i));
    check32("irq_not_yet", {31'h0, irq}, 32'd0);
    cyc(0, 0, 7'h00, 0, 0, 0);
    check32("irq_thr_hit", {31'h0, irq}, 32'd1);
    cyc(0, 1, 7'h05, 0, 0, 0);
    cyc(0, 0, 7'h00, 0, 0, 0);
    check32("irq_after_pop", {31'h0, irq}, 32'd0);
    cyc(0, 0, 7'h00, 0, 1, 32'h7);
    cyc(1, 1, 7'h02, 32'hFFFF_FFFF, 1, 32'h8);
    check32("midrst_rdat", rdat, 32'h0);
    check32("midrst_ctrl", ctrl, 32'h0);
    check32("midrst_irq", {31'h0, irq}, 32'h0);
    checkp("midrst_param", param, '0);
    cyc(0, 0, 7'h03, 0, 0, 0);
    check32("midrst_empty", rdat, 32'h0000_0001);

    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: ra = 7'($urandom_range(0, 6));
        7, 8:                ra = 7'(16 + $urandom_range(0, NP - 1));
        default:             ra = 7'($urandom);
      endcase
      rd = $urandom;
      if (ra == 7'h03 && $urandom_range(0, 1) == 1) rd = 32'h4;
      if (ra == 7'h02 && $urandom_range(0, 1) == 1) rd = {8'($urandom_range(0, 17)), 24'($urandom)};
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 40, ra, rd,
          $urandom_range(0, 99) < 55, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmdspi_regs.md
# cmdspi_regs

Register bank directly downstream of the `cmdspi` SPI command slave. It consumes the slave's `we`/`addr`/`wdat` bus and returns `rdat`, so a host can control the DSP datapath over SPI. It also buffers DSP result samples in a small FIFO that the host drains over SPI.

## Interface
Parameters:
- `ID_VALUE`, 32'h1CE4_0001: constant returned by the ID register.
- `FIFO_DEPTH`, 16: sample FIFO depth in words. Must be a power of two, 2..256.
- `NPARAM`, 8: number of parameter registers, 1..16.

Ports (clock and reset first):
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `we`, in, 1: one-cycle write strobe from `cmdspi`.
- `addr`, in, 7: register address, stable for the whole SPI frame.
- `wdat`, in, 32: write data, valid while `we`=1.
- `rdat`, out, 32: read data to `cmdspi`.
- `ctrl`, out, 32: CTRL register contents, driven to the DSP core.
- `param`, out, 32*NPARAM: parameter registers, flattened. Register k occupies bits [32k+31:32k].
- `s_valid`, in, 1: DSP sample strobe.
- `s_data`, in, 32: DSP sample.
- `irq`, out, 1: level output, = (level ≥ CTRL[31:24] and CTRL[24+:8]≠0) or overflow.

## Operation
Register map (32-bit words):
- 0x00 ID: RO, `ID_VALUE`.
- 0x01 SCRATCH: RW, reset 0.
- 0x02 CTRL: RW, reset 0. Bits [31:24] are the irq threshold; the rest are opaque to this block.
- 0x03 STATUS: RO except bit 2.
  - bit 0: empty.
  - bit 1: full.
  - bit 2: overflow, sticky. Write 1 to clear.
  - bits [23:16]: level.
- 0x04 FIFO_DATA: RO, FIFO head word. Reads 0 when empty.
- 0x05 FIFO_POP: WO. Any write pops one word if not empty; a write while empty is ignored. Reads 0.
- 0x06 SAMPLE_CNT: RO, 32-bit count of accepted pushes, wraps. Any write clears it.
- 0x10..0x10+NPARAM-1 PARAM[k]: RW, reset 0.
- Unmapped addresses read 0; writes to them are ignored.

FIFO behaviour:
- Push when `s_valid`=1 and not full.
- `s_valid`=1 while full drops the sample and sets overflow.
- Push and pop in the same cycle:
  - When full: the pop frees a slot and the push is accepted, so level is unchanged and no overflow.
  - When empty: only the push occurs; the pop is ignored.
- Overflow set and W1C in the same cycle: set wins.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Level is log2(FIFO_DEPTH)+1 bits, zero-extended into the STATUS field.
- SAMPLE_CNT increments only on accepted pushes. Clear and accepted push in the same cycle: SAMPLE_CNT = 1.

## Timing
- Reset values (cycle after `rst` sampled high): `rdat`=0, `ctrl`=0, `param`=0, `irq`=0; FIFO empty, overflow=0, SAMPLE_CNT=0.
- Reset takes priority over `we` and `s_valid` in the same cycle. Reset mid-frame flushes FIFO contents.
- Writes: the register updates on the edge where `we`=1. The new value is visible on `ctrl`/`param` in the next cycle.
- Read latency: `rdat` is registered, `rdat` ← mux(`addr`, current state) every cycle, i.e. 1 cycle after any `addr` or state change. `cmdspi` samples `rdat` ≥ 8 SCLK periods after `addr` settles, so 1 cycle is sufficient.
- FIFO_DATA after a pop: the new head appears on `rdat` 2 cycles after the `we` edge (pointer update, then rdat register).
- `irq` is registered, 1 cycle after the state change that causes it.
- Back-to-back `we` on consecutive cycles must be handled, one register write per cycle.

## Structure
- Package `cmdspi_regs_pkg`: address constants (`ADDR_ID`…`ADDR_PARAM0`), STATUS bit positions, default `ID_VALUE`.
- One sub-module `sync_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop/din/dout(head)/full/empty/level.
  - Inferred RAM with pointer logic. Shows the head word combinationally (first-word fall-through).
- Top: register file, address decode, read mux, sticky logic, counter.

## Test plan
- Reset, then read 0x00 → 32'h1CE40001. Read 0x03 → 32'h00000001 (empty).
- Write 0x01=32'h12345678, PARAM[3] (0x13)=32'hA5A5A5A5. Read back both → same values. `param[127:96]`=A5A5A5A5 on the cycle after `we`.
- Push 3 samples 0x11, 0x22, 0x33:
  - Read 0x04 → 0x11; STATUS[23:16] → 3.
  - Write 0x05, then read 0x04 → 0x22 within 2 cycles.
- Push 17 samples with depth 16 → STATUS = full|overflow, level 16, SAMPLE_CNT=16. Write 0x03=4 → overflow clears, full remains.
- With FIFO full, `s_valid` coinciding with a POP write → level stays 16, overflow stays 0, SAMPLE_CNT increments.
- Set CTRL[31:24]=4, push 4 samples → `irq`=1 one cycle after the 4th push. Pop one → `irq`=0. Assert `rst` mid-sequence → all outputs 0 and FIFO empty on the next cycle.
